// File: rtl/if_stage_pkg.sv
// ---------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch stage of the 16-bit MIPS core.
//
// Contents:
//   - instruction word layouts:
//       R-type: op[15:13] rs[12:10] rt[9:7] rd[6:4]   funct[3:0]
//       I-type: op[15:13] rs[12:10] rt[9:7] imm7[6:0]
//   - opcode constants (OP_RTYPE, OP_BEQ, OP_ADDI)
//   - the bubble word (add $0,$0,$0) and the PC increment
//   - the fetch action enum (RUN / HOLD / FLUSH)
//   - alignPc helper that forces a byte address onto a halfword boundary
// ---------------------------------------------------------------------------
package if_stage_pkg;

    // Bubble word inserted into IF/ID on flush or reset: add $0,$0,$0.
    localparam logic [15:0] NOP_WORD = 16'h0000;

    // Every instruction is two bytes long.
    localparam logic [15:0] PC_INC = 16'd2;

    // Major opcodes held in op[15:13].
    typedef enum logic [2:0] {
        OP_RTYPE = 3'd0,
        OP_BEQ   = 3'd2,
        OP_ADDI  = 3'd3
    } opcode_e;

    // Register-register format.
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [2:0] rd;
        logic [3:0] funct;
    } rtype_t;

    // Register-immediate / branch format.
    typedef struct packed {
        logic [2:0] op;
        logic [2:0] rs;
        logic [2:0] rt;
        logic [6:0] imm7;
    } itype_t;

    // Both views share the same 16 bits, so decode can pick either one.
    typedef union packed {
        rtype_t r;
        itype_t i;
    } instr_t;

    // What the fetch stage does on the coming edge.
    typedef enum logic [1:0] {
        ACT_RUN   = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } fetch_action_e;

    // Instructions live on halfword boundaries, so bit 0 is always cleared.
    function automatic logic [15:0] alignPc(input logic [15:0] addr);
        return addr & 16'hFFFE;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// ---------------------------------------------------------------------------
// if_stage_if
// Bundles the fetch stage's memory, hazard, branch and IF/ID signals.
//
// Signals:
//   iaddr       byte address to instruction memory (driven by fetch)
//   idata       instruction word returned combinationally for iaddr
//   stall       hazard unit hold request
//   redirect    taken branch / jump, fetch from redirect_pc
//   redirect_pc byte target address (bit 0 ignored)
//   ifid_instr  registered instruction for decode
//   ifid_pc2    registered PC+2 of that instruction
//   ifid_valid  1 = real instruction, 0 = bubble
//   fetch_count number of instructions accepted into IF/ID (wraps)
//
// Modports:
//   master  the fetch stage itself
//   slave   memory, hazard unit, branch logic and decode around it
// ---------------------------------------------------------------------------
interface if_stage_if;

    logic [15:0] iaddr;
    logic [15:0] idata;
    logic        stall;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc2;
    logic        ifid_valid;
    logic [15:0] fetch_count;

    modport master (
        output iaddr,
        output ifid_instr,
        output ifid_pc2,
        output ifid_valid,
        output fetch_count,
        input  idata,
        input  stall,
        input  redirect,
        input  redirect_pc
    );

    modport slave (
        input  iaddr,
        input  ifid_instr,
        input  ifid_pc2,
        input  ifid_valid,
        input  fetch_count,
        output idata,
        output stall,
        output redirect,
        output redirect_pc
    );

endinterface

// File: rtl/if_stage_pc_reg.sv
// ---------------------------------------------------------------------------
// if_stage_pc_reg
// Program counter register with load / hold / increment and a reset value.
//
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous, active-high; loads RESET_PC
//   load_i     load target_i (takes precedence over advance_i)
//   advance_i  step the PC by one instruction
//   target_i   byte address to load; bit 0 is ignored
//   pc_o       current PC (registered)
//   pcPlus2_o  address of the next sequential instruction
// ---------------------------------------------------------------------------
module if_stage_pc_reg
    import if_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        load_i,
    input  logic        advance_i,
    input  logic [15:0] target_i,
    output logic [15:0] pc_o,
    output logic [15:0] pcPlus2_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;
    logic [15:0] pcInc;

    // Sequential successor; 16-bit arithmetic makes 16'hFFFE roll to 0.
    assign pcInc = pc_q + PC_INC;

    // Next-PC selection: a load beats an advance, otherwise the PC holds.
    always_comb begin
        pc_d = pc_q;
        if (load_i) begin
            pc_d = alignPc(target_i);
        end else if (advance_i) begin
            pc_d = pcInc;
        end
    end

    // PC register with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= alignPc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o      = pc_q;
    assign pcPlus2_o = pcInc;

endmodule

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage of the 16-bit pipelined MIPS core. Drives the
// instruction-memory address from the PC, captures the returned word into
// the IF/ID register one cycle later and counts accepted instructions.
//
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous, active-high
//   bus     if_stage_if.master: iaddr/idata memory pair, stall, redirect,
//           redirect_pc, and the IF/ID outputs ifid_instr, ifid_pc2,
//           ifid_valid plus fetch_count
//
// Per-edge priority: reset > redirect > stall > normal advance.
// All outputs are registered; iaddr is a straight copy of the PC register.
// ---------------------------------------------------------------------------
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = NOP_WORD
) (
    input  logic       clock,
    input  logic       reset,
    if_stage_if.master bus
);

    fetch_action_e action;

    logic [15:0] pc;
    logic [15:0] pcPlus2;

    instr_t      ifidInstr_q;
    instr_t      ifidInstr_d;
    logic [15:0] ifidPc2_q;
    logic [15:0] ifidPc2_d;
    logic        ifidValid_q;
    logic        ifidValid_d;
    logic [15:0] fetchCount_q;
    logic [15:0] fetchCount_d;

    // Pick this edge's action; redirect overrides stall so a taken branch is
    // never lost behind a hazard hold.
    always_comb begin
        action = ACT_RUN;
        if (bus.redirect) begin
            action = ACT_FLUSH;
        end else if (bus.stall) begin
            action = ACT_HOLD;
        end
    end

    if_stage_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pcReg (
        .clock     (clock),
        .reset     (reset),
        .load_i    (action == ACT_FLUSH),
        .advance_i (action == ACT_RUN),
        .target_i  (bus.redirect_pc),
        .pc_o      (pc),
        .pcPlus2_o (pcPlus2)
    );

    // IF/ID next state. idata is only looked at in the RUN branch, so a
    // garbage word during a stall or redirect never reaches the register.
    always_comb begin
        ifidInstr_d  = ifidInstr_q;
        ifidPc2_d    = ifidPc2_q;
        ifidValid_d  = ifidValid_q;
        fetchCount_d = fetchCount_q;
        case (action)
            ACT_RUN: begin
                ifidInstr_d  = bus.idata;
                ifidPc2_d    = pcPlus2;
                ifidValid_d  = 1'b1;
                fetchCount_d = fetchCount_q + 16'd1;
            end
            ACT_FLUSH: begin
                ifidInstr_d = NOP_INSTR;
                ifidPc2_d   = 16'h0000;
                ifidValid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // IF/ID register and fetch counter; reset leaves a bubble behind.
    always_ff @(posedge clock) begin
        if (reset) begin
            ifidInstr_q  <= NOP_INSTR;
            ifidPc2_q    <= 16'h0000;
            ifidValid_q  <= 1'b0;
            fetchCount_q <= 16'h0000;
        end else begin
            ifidInstr_q  <= ifidInstr_d;
            ifidPc2_q    <= ifidPc2_d;
            ifidValid_q  <= ifidValid_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign bus.iaddr       = pc;
    assign bus.ifid_instr  = ifidInstr_q;
    assign bus.ifid_pc2    = ifidPc2_q;
    assign bus.ifid_valid  = ifidValid_q;
    assign bus.fetch_count = fetchCount_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
// Self-checking bench for if_stage: directed scenarios followed by random
// stall / redirect / reset traffic, all compared against a behavioural
// fetch model and a small instruction memory kept in the bench.
// ---------------------------------------------------------------------------
module tb_if_stage;

    localparam logic [15:0] RST_PC = 16'h0000;
    localparam logic [15:0] NOP    = 16'h0000;

    logic clock;
    logic reset;

    if_stage_if bus ();

    if_stage #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Instruction memory: 256 halfwords, address bits [8:1] pick the word.
    logic [15:0] mem [0:255];

    assign bus.idata = mem[bus.iaddr[8:1]];

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference state: what fetch should hold after each edge.
    logic [15:0] mPc;
    logic [15:0] mInstr;
    logic [15:0] mPc2;
    logic        mValid;
    logic [15:0] mCount;

    int checks;
    int failures;

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".iaddr"},       bus.iaddr,                mPc);
        checkOutput({tag, ".ifid_instr"},  bus.ifid_instr,           mInstr);
        checkOutput({tag, ".ifid_pc2"},    bus.ifid_pc2,             mPc2);
        checkOutput({tag, ".ifid_valid"},  {15'd0, bus.ifid_valid},  {15'd0, mValid});
        checkOutput({tag, ".fetch_count"}, bus.fetch_count,          mCount);
    endtask

    // One clock: drive at the falling edge, advance the model by the rules
    // (reset, then redirect, then stall, else fetch), sample 1 ns after the
    // rising edge.
    task automatic applyStimulus(input logic r, input logic s, input logic rd,
                                 input logic [15:0] rdPc, input string tag);
        @(negedge clock);
        reset           = r;
        bus.stall       = s;
        bus.redirect    = rd;
        bus.redirect_pc = rdPc;
        if (r) begin
            mPc = RST_PC; mInstr = NOP; mPc2 = 16'h0000; mValid = 1'b0; mCount = 16'h0000;
        end else if (rd) begin
            mPc = {rdPc[15:1], 1'b0}; mInstr = NOP; mPc2 = 16'h0000; mValid = 1'b0;
        end else if (!s) begin
            mInstr = mem[mPc[8:1]];
            mPc2   = mPc + 16'd2;
            mValid = 1'b1;
            mCount = mCount + 16'd1;
            mPc    = mPc + 16'd2;
        end
        @(posedge clock);
        #1;
        checkAll(tag);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        reset           = 1'b1;
        bus.stall       = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 16'h0000;
        mPc = 0; mInstr = 0; mPc2 = 0; mValid = 0; mCount = 0;

        // Reset, then four plain fetches.
        applyStimulus(1, 0, 0, 16'h0000, "reset");
        checkOutput("reset.iaddr_const", bus.iaddr, RST_PC);
        for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 16'h0000, "run");
        checkOutput("run4.iaddr_const", bus.iaddr, 16'h0008);
        checkOutput("run4.instr_word3", bus.ifid_instr, mem[3]);
        checkOutput("run4.count_const", bus.fetch_count, 16'd4);

        // Back to PC=4, stall three cycles, release.
        applyStimulus(1, 0, 0, 16'h0000, "reset2");
        applyStimulus(0, 0, 0, 16'h0000, "run");
        applyStimulus(0, 0, 0, 16'h0000, "run");
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 16'h0000, "stall");
        checkOutput("stall.iaddr_const", bus.iaddr, 16'h0004);
        checkOutput("stall.instr_word1", bus.ifid_instr, mem[1]);
        checkOutput("stall.pc2_const", bus.ifid_pc2, 16'h0004);
        applyStimulus(0, 0, 0, 16'h0000, "release");
        checkOutput("release.instr_word2", bus.ifid_instr, mem[2]);
        checkOutput("release.pc2_const", bus.ifid_pc2, 16'h0006);

        // At PC=6 redirect to odd address 3 -> fetch from 2.
        applyStimulus(0, 0, 1, 16'h0003, "redirect");
        checkOutput("redirect.iaddr_const", bus.iaddr, 16'h0002);
        checkOutput("redirect.valid_const", {15'd0, bus.ifid_valid}, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000, "postredir");
        checkOutput("postredir.instr_word1", bus.ifid_instr, mem[1]);

        // Redirect to the current PC still inserts a bubble and refetches.
        applyStimulus(0, 0, 1, bus.iaddr, "selfredir");
        applyStimulus(0, 0, 0, 16'h0000, "selfrefetch");

        // Back-to-back redirects, then redirect together with stall.
        applyStimulus(0, 0, 1, 16'h0040, "b2b1");
        applyStimulus(0, 0, 1, 16'h0080, "b2b2");
        applyStimulus(0, 0, 0, 16'h0000, "b2bfetch");
        applyStimulus(0, 1, 1, 16'h0000, "redirstall");
        checkOutput("redirstall.iaddr_const", bus.iaddr, 16'h0000);

        // PC wrap from 16'hFFFE.
        applyStimulus(0, 0, 1, 16'hFFFE, "toFFFE");
        applyStimulus(0, 0, 0, 16'h0000, "wrap");
        checkOutput("wrap.iaddr_const", bus.iaddr, 16'h0000);
        checkOutput("wrap.pc2_const", bus.ifid_pc2, 16'h0000);

        // Reset during an active stall at PC=10.
        applyStimulus(0, 0, 1, 16'h000A, "to10");
        applyStimulus(0, 1, 0, 16'h0000, "stall10");
        applyStimulus(1, 1, 0, 16'h0000, "resetInStall");
        checkOutput("resetInStall.count_const", bus.fetch_count, 16'h0000);
        applyStimulus(0, 0, 0, 16'h0000, "afterReset");

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic r, s, rd;
            r  = ($urandom_range(0, 99) < 3);
            s  = ($urandom_range(0, 99) < 25);
            rd = ($urandom_range(0, 99) < 15);
            applyStimulus(r, s, rd, 16'($urandom), "random");
        end

        // Run the counter up to 16'hFFFF, then one more fetch wraps it.
        for (int i = 0; i < 70000 && mCount != 16'hFFFF; i++)
            applyStimulus(0, 0, 0, 16'h0000, "countup");
        checkOutput("countup.reached_ffff", mCount, 16'hFFFF);
        applyStimulus(0, 0, 0, 16'h0000, "countwrap");
        checkOutput("countwrap.count_const", bus.fetch_count, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
